rtc_bus_sequencer: RTL

Sequences one transaction at a time on the external RTC's multiplexed address/data bus (Intel-style: CS_n, RD_n, WR_n, A_D, AD[7:0]).
- Sources of each transaction: the start levels and the address/data registers written by the PicoBlaze output-port block.
- Transaction types: a single write, a single read, or the fixed initialisation burst.
- On completion, pulses RESET_MAQUINA so the output-port block clears its start flag.
- Returns read data to the PicoBlaze input mux.

---
 rtl/rtc_pkg.sv | 32 +++
 rtl/rtc_phase_timer.sv | 28 ++
 rtl/rtc_bus_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared types and init-burst table for the RTC bus sequencer.
// Table entries are (register address, data) pairs written in order.
package rtc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_A_SETUP,
    S_A_STROBE,
    S_A_HOLD,
    S_D_SETUP,
    S_D_STROBE,
    S_D_HOLD,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    K_WRITE,
    K_READ,
    K_INIT
  } kind_e;

  localparam int INIT_LEN = 3;
  localparam int IDX_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

  localparam logic [INIT_LEN-1:0][7:0] INIT_ADDR = {
    8'h10, 8'h02, 8'h02
  };
  localparam logic [INIT_LEN-1:0][7:0] INIT_DATA = {
    8'hD2, 8'h00, 8'h10
  };

endpackage

// File: rtl/rtc_phase_timer.sv
// Bus-phase timer: loads T_PHASE-1 on phase entry and counts down.
// last_o marks the final cycle of the current phase.
module rtc_phase_timer #(
  parameter int T_PHASE = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic last_o
);

  localparam int CW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CW'(T_PHASE - 1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Sequences single writes, reads and the init burst on the RTC's
// multiplexed AD bus; all bus pins come straight from flops.
module rtc_bus_sequencer
  import rtc_pkg::*;
#(
  parameter int T_PHASE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arranque_inicio,
  input  logic       arranque_escribe,
  input  logic       arranque_lee,
  input  logic [7:0] REGISTRO_DIRECCION,
  input  logic [7:0] REGISTRO_DATO,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       A_D,
  output logic [7:0] dato_leido,
  output logic       RESET_MAQUINA,
  output logic       ocupado
);

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic             load, last;

  logic [7:0] ad_out_q, ad_out_d;
  logic [7:0] dato_q;
  logic       oe_q, oe_d;
  logic       cs_q, cs_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       a_d_q, a_d_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       is_rd;

  rtc_phase_timer #(
    .T_PHASE(T_PHASE)
  ) u_timer (
    .clk_i (clk),
    .rst_ni(reset),
    .load_i(load),
    .last_o(last)
  );

  assign idx_nxt = idx_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    data_d  = data_q;
    idx_d   = idx_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arranque_inicio | arranque_escribe | arranque_lee) begin
          state_d = S_A_SETUP;
          load    = 1'b1;
          idx_d   = '0;
          priority case (1'b1)
            arranque_inicio: begin
              kind_d = K_INIT;
              addr_d = INIT_ADDR[0];
              data_d = INIT_DATA[0];
            end
            arranque_escribe: begin
              kind_d = K_WRITE;
              addr_d = REGISTRO_DIRECCION;
              data_d = REGISTRO_DATO;
            end
            default: begin
              kind_d = K_READ;
              addr_d = REGISTRO_DIRECCION;
              data_d = REGISTRO_DATO;
            end
          endcase
        end
      end
      S_D_HOLD: begin
        if (last) begin
          if (kind_q == K_INIT && idx_q != IDX_W'(INIT_LEN - 1)) begin
            idx_d   = idx_nxt;
            addr_d  = INIT_ADDR[idx_nxt];
            data_d  = INIT_DATA[idx_nxt];
            state_d = S_A_SETUP;
            load    = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        if (last) begin
          state_d = state_e'(state_q + 3'd1);
          load    = 1'b1;
        end
      end
    endcase

    // Bus pins are decoded from the next state so they flop in lockstep with it.
    is_rd    = (kind_d == K_READ);
    cs_d     = 1'b1;
    rd_d     = 1'b1;
    wr_d     = 1'b1;
    a_d_d    = 1'b0;
    oe_d     = 1'b0;
    ad_out_d = 8'h00;
    done_d   = 1'b0;
    busy_d   = (state_d != S_IDLE);
    unique case (state_d)
      S_A_SETUP, S_A_HOLD: begin
        cs_d     = 1'b0;
        oe_d     = 1'b1;
        ad_out_d = addr_d;
      end
      S_A_STROBE: begin
        cs_d     = 1'b0;
        oe_d     = 1'b1;
        wr_d     = 1'b0;
        ad_out_d = addr_d;
      end
      S_D_SETUP, S_D_HOLD: begin
        cs_d     = 1'b0;
        a_d_d    = 1'b1;
        oe_d     = !is_rd;
        ad_out_d = is_rd ? 8'h00 : data_d;
      end
      S_D_STROBE: begin
        cs_d     = 1'b0;
        a_d_d    = 1'b1;
        oe_d     = !is_rd;
        ad_out_d = is_rd ? 8'h00 : data_d;
        wr_d     = is_rd;
        rd_d     = !is_rd;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      kind_q   <= K_WRITE;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      idx_q    <= '0;
      ad_out_q <= 8'h00;
      oe_q     <= 1'b0;
      cs_q     <= 1'b1;
      rd_q     <= 1'b1;
      wr_q     <= 1'b1;
      a_d_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      dato_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      ad_out_q <= ad_out_d;
      oe_q     <= oe_d;
      cs_q     <= cs_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      a_d_q    <= a_d_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      if (state_q == S_D_STROBE && kind_q == K_READ && last) begin
        dato_q <= ad_in;
      end
    end
  end

  assign ad_out        = ad_out_q;
  assign ad_oe         = oe_q;
  assign CS_n          = cs_q;
  assign RD_n          = rd_q;
  assign WR_n          = wr_q;
  assign A_D           = a_d_q;
  assign dato_leido    = dato_q;
  assign RESET_MAQUINA = done_q;
  assign ocupado       = busy_q;

endmodule
